// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: command codes, word width and FSM states.
package mem_responder_pkg;

    localparam int WORD = 16;

    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [1:0] MEM_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        MR_IDLE    = 2'd0,
        MR_WAIT    = 2'd1,
        MR_RESP    = 2'd2,
        MR_RELEASE = 2'd3
    } mrState_e;

endpackage

// File: rtl/mem_responder_array.sv
// Single-port word store: synchronous write, combinational read.
// The responder registers the read word itself, so no output register here.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = WORD,
    parameter int AW     = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] store [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            store[addr] <= wdata;
        end
    end

    assign rdata = store[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder with a four-phase mode/ready handshake.
// Optional out-of-range / reserved-command error reporting: define MEMRESP_ERR_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_W  = WORD,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_mode,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    mrState_e          stateReg, stateNext;
    logic [CW-1:0]     cntReg, cntNext;
    logic [AW-1:0]     addrReg;
    logic [DATA_W-1:0] wdataReg;
    logic [1:0]        modeReg;
    logic              errReg;
    logic [DATA_W-1:0] rdataReg;

    logic              isReq, reqErr, accept, loadRdata, curErr, arrWe;
    logic [1:0]        curMode;
    logic [AW-1:0]     arrAddr;
    logic [DATA_W-1:0] arrRdata;

`ifdef MEMRESP_ERR_EN
    assign isReq  = (mem_mode != MEM_IDLE);
    assign reqErr = (mem_mode == MEM_RSVD) || ({1'b0, mem_addr} >= (ADDR_W+1)'(DEPTH));
    assign mem_err = (stateReg == MR_RESP) && errReg;
`else
    assign isReq  = (mem_mode == MEM_READ) || (mem_mode == MEM_WRITE);
    assign reqErr = 1'b0;
    assign mem_err = 1'b0;
    // Addresses wrap modulo DEPTH, so the high address bits are deliberately dropped.
    if (AW < ADDR_W) begin : gUnusedHi
        logic unusedHiBits;
        assign unusedHiBits = ^mem_addr[ADDR_W-1:AW];
    end
`endif

    assign accept = (stateReg == MR_IDLE) && isReq;

    // In IDLE the operands are not latched yet; a LATENCY of 1 needs them straight from the inputs.
    assign curMode = (stateReg == MR_IDLE) ? mem_mode : modeReg;
    assign curErr  = (stateReg == MR_IDLE) ? reqErr : errReg;
    assign arrAddr = (stateReg == MR_IDLE) ? mem_addr[AW-1:0] : addrReg;

    assign loadRdata = (stateNext == MR_RESP) && (stateReg != MR_RESP) && (curMode == MEM_READ);
    assign arrWe     = (stateReg == MR_RESP) && (modeReg == MEM_WRITE) && !errReg && !reset;

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            MR_IDLE: begin
                if (isReq) begin
                    cntNext   = CNT_LOAD;
                    stateNext = (LATENCY == 1) ? MR_RESP : MR_WAIT;
                end
            end
            MR_WAIT: begin
                cntNext = cntReg - CW'(1);
                if (cntReg == CW'(1)) begin
                    stateNext = MR_RESP;
                end
            end
            MR_RESP:    stateNext = MR_RELEASE;
            MR_RELEASE: begin
                if (mem_mode == MEM_IDLE) begin
                    stateNext = MR_IDLE;
                end
            end
            default:    stateNext = MR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= MR_IDLE;
            cntReg   <= '0;
            addrReg  <= '0;
            wdataReg <= '0;
            modeReg  <= MEM_IDLE;
            errReg   <= 1'b0;
            rdataReg <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            if (accept) begin
                addrReg  <= mem_addr[AW-1:0];
                wdataReg <= mem_wdata;
                modeReg  <= mem_mode;
                errReg   <= reqErr;
            end
            if (loadRdata) begin
                rdataReg <= curErr ? '0 : arrRdata;
            end
        end
    end

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) uArray (
        .clk   (clk),
        .we    (arrWe),
        .addr  (arrAddr),
        .wdata (wdataReg),
        .rdata (arrRdata)
    );

    assign mem_rdata = rdataReg;
    assign mem_ready = (stateReg == MR_RESP);
    assign mem_busy  = (stateReg != MR_IDLE);

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle control unit's memory interface. It accepts read/write commands driven by the controller's memory mode signal together with the MAR address and MDR write data. After a fixed latency it completes the access and returns read data with a one-cycle ready pulse. It sits between the MAR/MDR datapath registers and the word-addressed main store, and owns the storage array.

## Interface

Parameters:
- `DATA_W`, 16: word width; matches the codebase `WORD` width.
- `ADDR_W`, 16: address width driven from MAR.
- `DEPTH`, 4096: number of words implemented; must be ≤ 2^`ADDR_W`.
- `LATENCY`, 2: cycles from accept to ready; must be ≥ 1.

Ports (`clk` is the single clock; `reset` is synchronous, active-high):
- `clk`, input, 1: clock; all state updates on posedge.
- `reset`, input, 1: synchronous, active-high.
- `mem_mode`, input, 2: command. 00 idle, 01 read, 10 write, 11 reserved.
- `mem_addr`, input, `ADDR_W`: word address, from MAR.
- `mem_wdata`, input, `DATA_W`: write data, from MDR.
- `mem_rdata`, output, `DATA_W`: read data, toward MDR.
- `mem_ready`, output, 1: one-cycle completion pulse.
- `mem_busy`, output, 1: high from accept until release.
- `mem_err`, output, 1: out-of-range flag; only meaningful with `MEMRESP_ERR_EN`.

## Operation

The state machine has four states: IDLE, WAIT, RESP and RELEASE.

- **IDLE:** A posedge with `mem_mode` of 01 or 10 accepts the request.
  - `mem_addr`, `mem_wdata` and the mode are latched.
  - The latency counter loads `LATENCY-1`.
  - Next state is RESP if `LATENCY`==1, otherwise WAIT.
  - Modes 00 and 11 are ignored and the block stays in IDLE.
- **WAIT:** The counter decrements each cycle. On reaching 0, the state moves to RESP. Input changes are ignored because the operands are already latched.
- **RESP:** `mem_ready`=1 for exactly this cycle.
  - Read: `mem_rdata` shows the array word at the latched address.
  - Write: the latched data commits to the array at the posedge that ends RESP.
  - Next state is RELEASE.
- **RELEASE:** The block waits for `mem_mode`==00, then returns to IDLE. A request that is still held is never re-accepted. This is a four-phase handshake: the controller must drop the mode after seeing ready.

Output behaviour:
- `mem_rdata` is registered. It updates only on read completion and holds its value through later writes and idle cycles.
- `mem_busy` = (state ≠ IDLE).
- Read-after-write to the same address returns the new data, because the write commits before RELEASE.

Reset and boundary conditions:
- **Reset values:** state IDLE, `mem_ready`=0, `mem_busy`=0, `mem_err`=0, `mem_rdata`=0, counter=0.
- **Array contents:** not cleared by reset.
- **Reset mid-operation:** a pending write is discarded with no array update. No ready pulse is emitted.
- **Reset and request in the same cycle:** reset wins and the request is not accepted.

## Timing

- Request sampled at posedge N → `mem_ready` high during cycle N+`LATENCY`.
- Read data is valid in the same cycle as `mem_ready`.
- Write is visible to a read accepted at posedge N+`LATENCY`+2 or later. That is the earliest possible accept, after a release in cycle N+`LATENCY`+1.
- Minimum spacing between back-to-back accepts: `LATENCY`+2 cycles.
- No combinational path from any input to any output.

## Configuration

- **`MEMRESP_ERR_EN` defined:**
  - An address ≥ `DEPTH` sets `mem_err`=1 during RESP, together with `mem_ready`.
  - Reads return 0; writes are dropped.
  - Mode 11 is accepted as an error request and completes with `mem_err`=1 and no access.
- **`MEMRESP_ERR_EN` undefined:**
  - Addresses are reduced modulo `DEPTH` (low bits used).
  - Mode 11 is ignored.
  - `mem_err` is tied to 0.

## Structure

- **Shared package / header** (alongside the existing signal definitions):
  - mode codes `MEM_IDLE`=2'b00, `MEM_READ`=2'b01, `MEM_WRITE`=2'b10, `MEM_RSVD`=2'b11;
  - the `WORD` width;
  - the state encodings `MR_IDLE`, `MR_WAIT`, `MR_RESP`, `MR_RELEASE`.
- **Sub-module `mem_array`:** a single-port `DEPTH`×`DATA_W` store with synchronous write and combinational read. It is instantiated once; the responder FSM registers the read output.

## Test plan

- Reset, then read addr 0x0005 with `LATENCY`=2, mode held → `mem_ready` pulses exactly once at cycle +2 and `mem_rdata` shows the preloaded word. Mode then dropped → `mem_busy` falls the next cycle.
- Write 0xBEEF to 0x0010, release, then read 0x0010 → `mem_rdata`=0xBEEF. `mem_rdata` is unchanged during the write phase.
- Mode held at 01 for 10 cycles → exactly one `mem_ready` pulse and no second accept until mode is 00.
- Reset asserted in WAIT during a write of 0x1234 to 0x0020 → no `mem_ready`, and a later read of 0x0020 returns the old value.
- With `MEMRESP_ERR_EN` defined, read 0x2000 (`DEPTH`=4096) → `mem_ready`=1, `mem_err`=1, `mem_rdata`=0. Without the macro, the same read returns the word at 0x0000 with `mem_err`=0.
- `LATENCY`=1: write then read at the maximum rate → accepts every 3 cycles and data is correct.
